// File: rtl/fetch_stage.sv
// IF stage and IF/ID pipeline register: owns the PC, issues instruction-memory
// reads, buffers a returned instruction while the pipeline is stalled, and
// discards a read that is still in flight when EX redirects the fetch.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0060,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hz_stall,
    input  logic        pipe_stall,
    input  logic        flush,
    input  logic [31:0] flush_target,
    output logic        imem_read,
    output logic [31:0] imem_address,
    input  logic        imem_resp,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] stale_pc_q;
    logic [31:0] buf_pc_q;
    logic [31:0] buf_instr_q;
    logic [31:0] if_id_pc_q;
    logic [31:0] if_id_instr_q;
    logic        if_id_valid_q;
    logic        read_q;

    logic        advance;
    logic        resp;
    logic [31:0] pc_plus4;
    logic [31:0] target_aligned;

    assign advance        = !hz_stall && !pipe_stall;
    // A response only counts while a request is actually being presented.
    assign resp           = imem_resp && read_q;
    assign pc_plus4       = pc_q + 32'd4;
    assign target_aligned = flush_target & ~32'h3;

    // While draining a stale read the address must stay on the old PC.
    assign imem_address = (state_q == DROP) ? stale_pc_q : pc_q;
    assign imem_read    = read_q;
    assign if_id_pc     = if_id_pc_q;
    assign if_id_instr  = if_id_instr_q;
    assign if_id_valid  = if_id_valid_q;

    // Fetch FSM, PC, stall buffer and IF/ID register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            stale_pc_q    <= '0;
            buf_pc_q      <= '0;
            buf_instr_q   <= '0;
            if_id_pc_q    <= '0;
            if_id_instr_q <= NOP_INSTR;
            if_id_valid_q <= 1'b0;
            read_q        <= 1'b0;
        end else begin
            // Request is asserted in every state except HOLD; HOLD paths override.
            read_q <= 1'b1;
            if (flush) begin
                if_id_pc_q    <= '0;
                if_id_instr_q <= NOP_INSTR;
                if_id_valid_q <= 1'b0;
                pc_q          <= target_aligned;
                case (state_q)
                    FETCH: begin
                        // Only a request actually on the bus needs draining.
                        if (read_q && !resp) begin
                            stale_pc_q <= pc_q;
                            state_q    <= DROP;
                        end
                    end
                    HOLD:    state_q <= FETCH;
                    DROP:    if (resp) state_q <= FETCH;
                    default: state_q <= FETCH;
                endcase
            end else begin
                case (state_q)
                    FETCH: begin
                        if (resp) begin
                            if (advance) begin
                                if_id_pc_q    <= pc_q;
                                if_id_instr_q <= imem_rdata;
                                if_id_valid_q <= 1'b1;
                                pc_q          <= pc_plus4;
                            end else begin
                                buf_pc_q    <= pc_q;
                                buf_instr_q <= imem_rdata;
                                state_q     <= HOLD;
                                read_q      <= 1'b0;
                            end
                        end else if (advance) begin
                            if_id_pc_q    <= pc_q;
                            if_id_instr_q <= NOP_INSTR;
                            if_id_valid_q <= 1'b0;
                        end
                    end
                    HOLD: begin
                        if (advance) begin
                            if_id_pc_q    <= buf_pc_q;
                            if_id_instr_q <= buf_instr_q;
                            if_id_valid_q <= 1'b1;
                            pc_q          <= pc_plus4;
                            state_q       <= FETCH;
                        end else begin
                            read_q <= 1'b0;
                        end
                    end
                    DROP: begin
                        if (resp) state_q <= FETCH;
                        if (advance) begin
                            if_id_pc_q    <= pc_q;
                            if_id_instr_q <= NOP_INSTR;
                            if_id_valid_q <= 1'b0;
                        end
                    end
                    default: state_q <= FETCH;
                endcase
            end
        end
    end

endmodule
